// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the fetch-side, data-side and shared-memory signals of mem_arbiter.
// Latency: none, this is wiring only.
// Backpressure: requests are held high by the requester until its ack pulse comes back.
interface mem_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifAck;
  logic [31:0] ifData;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [31:0] dmWData;
  logic        dmAck;
  logic [31:0] dmData;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memRData;
  logic        busy;

  // Arbiter side: takes requests and memory read data, returns acks and the memory strobes.
  modport slave (
    input  ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWData, memRData,
    output ifAck, ifData, dmAck, dmData, memAddr, memWData, memRead, memWrite, busy
  );

  // Requester/memory side: the mirror image of the arbiter view.
  modport master (
    output ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWData, memRData,
    input  ifAck, ifData, dmAck, dmData, memAddr, memWData, memRead, memWrite, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access (IDLE/BUSY/DONE FSM).
// Latency: a request sampled in IDLE gets its ack LATENCY+1 cycles later; one transaction per LATENCY+2 cycles.
// Backpressure: requests are only sampled in IDLE; a held request waits through BUSY/DONE.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-break, otherwise the data side wins ties.
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_DM   = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        grant, grant_nxt;
  logic        lat_we, lat_we_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [31:0] lat_wdata, lat_wdata_nxt;
  logic [31:0] if_data, dm_data;
  logic        capture;
  logic        tie_dm;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // A tie goes to whichever side was not served last.
  assign tie_dm = (last_grant == GNT_IF);

  // Remember the side of every grant taken in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant <= GNT_IF;
    else if (state == IDLE && (bus.ifReq || bus.dmReq))
      last_grant <= grant_nxt;
  end
`else
  // Data side is the older pipeline stage, so it always wins a tie.
  assign tie_dm = 1'b1;
`endif

  // FSM state and latched transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      grant     <= GNT_IF;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      lat_we    <= lat_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
    end
  end

  // Next-state decode and all memory/ack outputs; mem strobes are only driven in BUSY.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    capture       = 1'b0;
    bus.memAddr   = 32'd0;
    bus.memWData  = 32'd0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.ifAck     = 1'b0;
    bus.dmAck     = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.ifReq || bus.dmReq) begin
          grant_nxt = (bus.dmReq && (!bus.ifReq || tie_dm)) ? GNT_DM : GNT_IF;
          if (grant_nxt == GNT_DM) begin
            lat_addr_nxt  = bus.dmAddr;
            lat_we_nxt    = bus.dmWe;
            lat_wdata_nxt = bus.dmWData;
          end else begin
            lat_addr_nxt  = bus.ifAddr;
            lat_we_nxt    = 1'b0;
            lat_wdata_nxt = 32'd0;
          end
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.memAddr  = lat_addr;
        bus.memWData = lat_wdata;
        bus.memRead  = !lat_we;
        // Single write strobe on the final access cycle.
        bus.memWrite = lat_we && (cnt == 4'd0);
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          capture   = !lat_we;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.ifAck = (grant == GNT_IF);
        bus.dmAck = (grant == GNT_DM);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read-data registers: only the granted side is updated, and only by a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data <= 32'd0;
      dm_data <= 32'd0;
    end else if (capture) begin
      if (grant == GNT_IF)
        if_data <= bus.memRData;
      else
        dm_data <= bus.memRData;
    end
  end

  assign bus.ifData = if_data;
  assign bus.dmData = dm_data;

endmodule
